// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: CPU request port, video fetch port and the
// synchronous RAM port, plus the arbiter busy flag.
//   slave  : arbiter view (takes requests and RAM read data, drives acks and RAM strobes)
//   master : environment view (drives requests and RAM read data)
interface ram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  logic        vid_req;
  logic [15:0] vid_adr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;

  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_adr;
  logic [7:0]  ram_dbi;
  logic [7:0]  ram_dbo;

  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata, vid_req, vid_adr, ram_dbo,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata, ram_en, ram_we, ram_adr, ram_dbi, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata, vid_req, vid_adr, ram_dbo,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata, ram_en, ram_we, ram_adr, ram_dbi, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one synchronous RAM (1-cycle read latency) between a CPU
// (read/write) and a video fetcher (read only).
//   phi   : clock, all state on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_arbiter_if.slave -- request/ack/rdata per requester, RAM strobes, busy
// Each transaction runs IDLE -> ACCESS -> DONE; the ack pulse appears two edges after the
// grant edge regardless of direction or address range. Addresses >= RAM_LIMIT never strobe
// the RAM; reads there return 8'h00 and writes are dropped. Ties go to the requester that
// was not granted last.
module ram_arbiter #(
  parameter logic [15:0] RAM_LIMIT = 16'hB000
) (
  input logic          phi,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q;
  logic        owner_vid_q;  // owner of the transaction in flight
  logic        last_vid_q;   // last grant went to video
  logic        we_q;
  logic        in_range_q;
  logic        cpu_ack_q;
  logic        vid_ack_q;
  logic        ram_en_q;
  logic        ram_we_q;
  logic        busy_q;
  logic [7:0]  cpu_rdata_q;
  logic [7:0]  vid_rdata_q;
  logic [7:0]  ram_dbi_q;
  logic [15:0] ram_adr_q;

  logic        cpu_elig;
  logic        vid_elig;
  logic        grant_any;
  logic        grant_vid;
  logic        sel_we;
  logic        sel_in_range;
  logic [15:0] sel_adr;
  logic [7:0]  sel_wdata;

  // The ack is registered on the DONE edge, so it is high in the first IDLE cycle. A
  // requester still holding req during its own ack cycle is ignored there; the other
  // requester may be granted on that edge, which keeps dual traffic strictly alternating.
  always_comb begin
    cpu_elig     = bus.cpu_req & ~cpu_ack_q;
    vid_elig     = bus.vid_req & ~vid_ack_q;
    grant_any    = cpu_elig | vid_elig;
    grant_vid    = vid_elig & (~cpu_elig | ~last_vid_q);
    sel_adr      = grant_vid ? bus.vid_adr : bus.cpu_adr;
    sel_we       = ~grant_vid & bus.cpu_we;
    sel_wdata    = grant_vid ? 8'h00 : bus.cpu_wdata;
    sel_in_range = sel_adr < RAM_LIMIT;
  end

  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_vid_q <= 1'b0;
      last_vid_q  <= 1'b1;  // CPU wins the first tie
      we_q        <= 1'b0;
      in_range_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      cpu_rdata_q <= 8'h00;
      vid_rdata_q <= 8'h00;
      ram_dbi_q   <= 8'h00;
      ram_adr_q   <= 16'h0000;
    end else begin
      cpu_ack_q <= 1'b0;
      vid_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            state_q     <= StAccess;
            owner_vid_q <= grant_vid;
            last_vid_q  <= grant_vid;
            we_q        <= sel_we;
            in_range_q  <= sel_in_range;
            // RAM strobes are loaded here so they are valid throughout ACCESS.
            ram_adr_q   <= sel_adr;
            ram_dbi_q   <= sel_wdata;
            ram_en_q    <= sel_in_range;
            ram_we_q    <= sel_in_range & sel_we;
            busy_q      <= 1'b1;
          end
        end
        StAccess: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          state_q  <= StDone;
        end
        StDone: begin
          // ram_dbo carries the read data during DONE (one cycle after the strobe).
          if (owner_vid_q) begin
            vid_ack_q <= 1'b1;
            if (!we_q) vid_rdata_q <= in_range_q ? bus.ram_dbo : 8'h00;
          end else begin
            cpu_ack_q <= 1'b1;
            if (!we_q) cpu_rdata_q <= in_range_q ? bus.ram_dbo : 8'h00;
          end
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_adr   = ram_adr_q;
  assign bus.ram_dbi   = ram_dbi_q;
  assign bus.busy      = busy_q;

endmodule
